result_stream_reader: RTL
=========================

# result_stream_reader

Read-out end of the result memory. The approximate-multiplier datapath writes 32-bit products into an 8-entry result memory through a `wr`/`addr`/`data_in` write port. This block owns that memory, accepts those writes unchanged, and on `start` streams all entries, in address order, over a 32-bit valid/ready interface to the downstream consumer. It replaces the write-only result RAM, giving the design an observable output.

## Interface
- `WIDTH`, 32: result word width.
- `DEPTH`, 8: number of entries; must be a power of two.
- `ADDR_W`, 3: address width; equals log2(`DEPTH`).

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset, synchronous, active-low; sampled only on the `clk` rising edge.
- `wr`  in  1  write enable, from the datapath.
- `addr`  in  `ADDR_W`  write address.
- `data_in`  in  `WIDTH`  write data.
- `start`  in  1  start-stream request; sampled in IDLE only.
- `out_valid`  out  1  `out_data` holds a valid word.
- `out_ready`  in  1  consumer accepts the word.
- `out_data`  out  `WIDTH`  streamed word.
- `out_last`  out  1  the current word is entry `DEPTH-1`.
- `busy`  out  1  stream in progress.
- `done`  out  1  one-cycle pulse after the final word is accepted.

## Operation
- Storage: `DEPTH` x `WIDTH` register array, plus pointer `ptr` (`ADDR_W` bits).
- Write port: when `wr`=1, mem[`addr`] <= `data_in` at the clock edge. Writes are legal in every state and have no effect on the FSM.
- Read is read-before-write: any load of `out_data` uses the array contents from before the same edge's write.
- FSM, two states:
  - IDLE: `busy`=0, `out_valid`=0. On `start`=1: go to SEND, `ptr`<=0, `out_data`<=mem[0], `out_valid`<=1.
  - SEND: `busy`=1. `out_valid` and `out_data` hold until handshake (`out_valid`&`out_ready`).
  - Handshake with `ptr`<`DEPTH-1`: `ptr`<=`ptr`+1, `out_data`<=mem[`ptr`+1], `out_valid` stays 1. No bubble between words.
  - Handshake with `ptr`=`DEPTH-1`: `out_valid`<=0, `done`<=1, `ptr`<=0, go to IDLE.
- `out_last` = `out_valid` & (`ptr`==`DEPTH-1`); combinational.
- `start` in SEND is ignored; it is not queued.
- `done` is high for exactly one cycle, the cycle after the last handshake. FSM is already in IDLE that cycle, so `start` during `done` is accepted.
- `out_ready` while `out_valid`=0 has no effect.
- Stream snapshot: each entry's value is captured when that entry is loaded into `out_data`.
  - A write to an entry not yet loaded appears in the stream.
  - A write to an entry already loaded, including the one currently presented, does not.
- `out_data` keeps its last value after the stream ends; it is don't-care while `out_valid`=0.

## Timing
- Reset (`rst`=0 at an edge): state IDLE, `ptr`=0, `out_valid`=0, `out_data`=0, `out_last`=0, `busy`=0, `done`=0, all memory entries 0.
  - Reset has priority over `wr` and `start` in the same cycle.
  - Reset mid-stream abandons the stream with no `done`.
- Latency from `start` to first `out_valid`: 1 cycle.
- Throughput: one word per cycle while `out_ready`=1. A full stream with `out_ready` held high takes `DEPTH` cycles from first valid, with `done` in the cycle after the last beat.
- Write-to-stream visibility: a write at edge N to entry k is seen if entry k is loaded at edge N+1 or later.

## Test plan
- Basic stream: write mem[i]=0x1000_0000+i for i=0..7, pulse `start` with `out_ready`=1. Required: 8 consecutive beats 0x1000_0000..0x1000_0007, `out_last` only on the 8th, `done` the next cycle, `busy` falling with it.
- Backpressure: same data, `out_ready` toggled 1,0,0,1,... Required: `out_data` stable while stalled, each word delivered exactly once in order, no skips or duplicates.
- Write during stream: after word 2 is accepted, write mem[5]=0xDEAD_BEEF and mem[1]=0x0BAD_F00D. Required: word 5 = 0xDEAD_BEEF, word 1 unchanged.
- Same-edge collision: stall on word 3, then in one cycle do handshake + `wr` mem[4]=0xCAFE_0004. Required: word 4 shows the old value. A second stream shows 0xCAFE_0004.
- `start` while `busy` is ignored, with exactly 8 beats. `start` in the `done` cycle launches a second full 8-beat stream.
- Reset mid-stream at word 3. Required: all outputs 0, no `done`. A following `start` streams 8 zero words.

Source files
------------

// File: rtl/result_stream_reader.sv
// Result memory with a write port from the datapath and a valid/ready read-out stream.
// On start, every entry is streamed in address order; each entry is sampled when it is loaded.
module result_stream_reader #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  data_in,
  input  logic              start,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t             state, state_n;
  logic [WIDTH-1:0]   mem [DEPTH];
  logic [ADDR_W-1:0]  ptr, ptr_n, ptr_inc;
  logic               valid_n;
  logic [WIDTH-1:0]   data_n;
  logic               done_n;

  // Non-blocking update means loads of out_data see the array as it was before this edge's write.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      ptr       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      done      <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      state     <= state_n;
      ptr       <= ptr_n;
      out_valid <= valid_n;
      out_data  <= data_n;
      done      <= done_n;
      if (wr) begin
        mem[addr] <= data_in;
      end
    end
  end

  assign ptr_inc = ptr + ADDR_W'(1);

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    valid_n = out_valid;
    data_n  = out_data;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = SEND;
          ptr_n   = '0;
          data_n  = mem[0];
          valid_n = 1'b1;
        end
      end
      SEND: begin
        if (out_valid && out_ready) begin
          if (ptr == LAST_IDX) begin
            state_n = IDLE;
            ptr_n   = '0;
            valid_n = 1'b0;
            done_n  = 1'b1;
          end else begin
            ptr_n  = ptr_inc;
            data_n = mem[ptr_inc];
          end
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign busy     = (state == SEND);
  assign out_last = out_valid && (ptr == LAST_IDX);

endmodule
